// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The slave modport is the subtractor side; the master modport is the producer/consumer side.
interface nibble_serial_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  borrow_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output borrow_out,
        output overflow
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output borrow_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  borrow_out,
        input  overflow
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: a - b - borrow_in, one 4-bit lookahead digit per clock, LSB first.
// Computed as a + ~b + ~borrow_in; borrow is the inverted carry.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input logic                        clk,
    input logic                        rst,
    nibble_serial_subtractor_if.slave  bus
);
    localparam int unsigned NumDigits = WIDTH / 4;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [CntW-1:0] LastDigit = CntW'(NumDigits - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q;       // minuend, shifted right one digit per BUSY cycle
    logic [WIDTH-1:0] nb_q;      // inverted subtrahend, shifted alongside a_q
    logic [WIDTH-1:0] res_q;     // sum digits enter from the MSB side
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic             a_sign_q;  // operand sign bits kept for the overflow rule,
    logic             b_sign_q;  // since the shift registers lose them
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             accept;
    logic             last_digit;
    logic [3:0]       a_dig, b_dig, g, p, c, sum;
    logic             grp_g, grp_p, cout;
    logic [WIDTH+3:0] res_cat;
    logic [WIDTH-1:0] res_next;

    assign accept     = (state_q == StIdle) && bus.in_valid;
    assign last_digit = (cnt_q == LastDigit);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid)  state_d = StBusy;
            StBusy:  if (last_digit)    state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // One 4-bit lookahead slice on the current low digit; carries are flat sum-of-products.
    always_comb begin
        a_dig = a_q[3:0];
        b_dig = nb_q[3:0];
        g     = a_dig & b_dig;
        p     = a_dig | b_dig;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & carry_q);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        cout  = grp_g | (grp_p & carry_q);
        sum   = a_dig ^ b_dig ^ c;
        // Concatenate then drop the low digit so WIDTH=4 needs no special case.
        res_cat  = {sum, res_q};
        res_next = res_cat[WIDTH+3:4];
    end

    // Operand capture and per-digit datapath; result outputs update only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            nb_q     <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.a;
            nb_q     <= ~bus.b;
            carry_q  <= ~bus.borrow_in;
            cnt_q    <= '0;
            a_sign_q <= bus.a[WIDTH-1];
            b_sign_q <= bus.b[WIDTH-1];
        end else if (state_q == StBusy) begin
            a_q     <= a_q >> 4;
            nb_q    <= nb_q >> 4;
            res_q   <= res_next;
            carry_q <= cout;
            cnt_q   <= cnt_q + CntW'(1);
            if (last_digit) begin
                diff_q   <= res_next;
                borrow_q <= ~cout;
                ovf_q    <= (a_sign_q != b_sign_q) && (res_next[WIDTH-1] != a_sign_q);
            end
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16) with an expected-result queue.
module tb_nibble_serial_subtractor;
    localparam int unsigned W = 16;
    localparam int unsigned N = W / 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic bin);
        logic [W:0] r;
        exp_t       e;
        r    = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bin};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
        return e;
    endfunction

    // Wait (bounded) for in_ready, present operands, push expected, scramble inputs while busy.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                          input exp_t e, output bit ok);
        int cyc = 0;
        ok = 1'b0;
        while (!bus.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.borrow_in = bin;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        bus.borrow_in = 1'($urandom);
        ok = 1'b1;
    endtask

    // Full operation; rnd_stall randomises out_ready while the result is offered.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin,
                         input exp_t e, input bit chk_lat, input bit rnd_stall);
        int   cyc;
        bit   ok;
        exp_t x;
        bus.out_ready = rnd_stall ? 1'($urandom) : 1'b1;
        launch(av, bv, bin, e, ok);
        if (!ok) return;
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        if (chk_lat) check("latency", cyc, N);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        x = sb.pop_front();
        check("diff", bus.diff, x.d);
        check("borrow_out", bus.borrow_out, x.bo);
        check("overflow", bus.overflow, x.ov);
        cyc = 0;
        do begin
            bus.out_ready = rnd_stall ? 1'($urandom) : 1'b1;
            @(negedge clk);
            cyc++;
        end while (bus.out_valid && cyc < 50);
        check("in_ready_after_done", bus.in_ready, 1'b1);
        bus.out_ready = 1'b0;
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        return e;
    endfunction

    initial begin
        bit   ok;
        exp_t e;
        logic [W-1:0] av, bv;
        logic bin;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b0;

        // Asynchronous reset takes effect without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_diff", bus.diff, 16'h0000);
        check("rst_borrow", bus.borrow_out, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_op(16'h1234, 16'h0123, 1'b0, mk(16'h1111, 1'b0, 1'b0), 1'b1, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0), 1'b1, 1'b0);
        do_op(16'h0005, 16'h0005, 1'b1, mk(16'hFFFF, 1'b1, 1'b0), 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b1), 1'b0, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b1), 1'b0, 1'b0);

        // Backpressure: DONE held for 10 cycles, stray in_valid ignored.
        bus.out_ready = 1'b0;
        e = mk(16'h7FFF, 1'b0, 1'b1);
        launch(16'h8000, 16'h0001, 1'b0, e, ok);
        if (ok) begin
            for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
            void'(sb.pop_front());
            for (int i = 0; i < 10; i++) begin
                check("bp_out_valid", bus.out_valid, 1'b1);
                check("bp_in_ready", bus.in_ready, 1'b0);
                check("bp_diff", bus.diff, e.d);
                check("bp_borrow", bus.borrow_out, e.bo);
                check("bp_overflow", bus.overflow, e.ov);
                bus.in_valid = (i == 3);
                bus.a        = 16'hAAAA;
                bus.b        = 16'h5555;
                @(negedge clk);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            check("bp_release_out_valid", bus.out_valid, 1'b0);
            check("bp_release_in_ready", bus.in_ready, 1'b1);
            bus.out_ready = 1'b0;
        end
        do_op(16'hABCD, 16'h1234, 1'b1, mk(16'h9998, 1'b0, 1'b0), 1'b1, 1'b0);

        // Asynchronous reset during the second BUSY cycle.
        launch(16'h4321, 16'h1111, 1'b0, mk(16'h3210, 1'b0, 1'b0), ok);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_diff", bus.diff, 16'h0000);
        check("mid_rst_borrow", bus.borrow_out, 1'b0);
        check("mid_rst_overflow", bus.overflow, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", bus.out_valid, 1'b0);
        do_op(16'h4321, 16'h1111, 1'b0, mk(16'h3210, 1'b0, 1'b0), 1'b1, 1'b0);

        // Randomised sweep with random out_ready stalls.
        for (int i = 0; i < 1000; i++) begin
            av  = W'($urandom);
            bv  = W'($urandom);
            bin = 1'($urandom);
            if (i % 8 == 0) bv = av;
            do_op(av, bv, bin, model(av, bv, bin), 1'b1, 1'b1);
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
